// File: rtl/game_pkg.sv
// Shared game constants: state encoding, screen geometry,
// coordinate widths and default sprite sizes.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        EXPLODE  = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int COORD_X_W    = 10;
    localparam int COORD_Y_W    = 10;
    localparam int SPR_PLAYER_W = 26;
    localparam int SPR_PROJ_W   = 2;
    localparam int SPR_PROJ_H   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Registered rising-edge detector; history resets high so a level
// held through reset is not seen as an edge.
module rising_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= 1'b1;
        else        in_q <= in_i;
    end

    assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/projectile_ctrl.sv
// Player projectile controller: launch on fire edge, climb per move
// tick, freeze for an explosion on hit, then cool down before re-fire.
module projectile_ctrl
    import game_pkg::*;
#(
    parameter int X_W            = COORD_X_W,
    parameter int Y_W            = COORD_Y_W,
    parameter int PLAYER_Y       = 440,
    parameter int PLAYER_W       = SPR_PLAYER_W,
    parameter int PROJ_W         = SPR_PROJ_W,
    parameter int PROJ_H         = SPR_PROJ_H,
    parameter int PROJ_SPEED     = 4,
    parameter int EXPLODE_TICKS  = 6,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_move,
    input  logic           fire,
    input  logic [X_W-1:0] player_x,
    input  logic           clear,
    input  logic           collision,
    output logic [X_W-1:0] proj_x,
    output logic [Y_W-1:0] proj_y,
    output logic           proj_active,
    output logic           exploding,
    output logic           hit_pulse,
    output logic           miss_pulse
);

    localparam int CNT_W =
        $clog2(max_int(EXPLODE_TICKS, COOLDOWN_TICKS) + 1);

    localparam logic [X_W:0] LAUNCH_OFF =
        (X_W+1)'(PLAYER_W / 2 - PROJ_W / 2);
    localparam logic [Y_W-1:0] LAUNCH_Y = Y_W'(PLAYER_Y - PROJ_H);
    localparam logic [Y_W-1:0] SPEED    = Y_W'(PROJ_SPEED);
    localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXPLODE_TICKS - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_TICKS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [X_W-1:0]   proj_x_q;
    logic [Y_W-1:0]   proj_y_q;
    logic             active_q;
    logic             expl_q;
    logic             hit_q;
    logic             miss_q;
    logic             fire_rise;

    rising_edge_detect u_fire_edge (
        .clk    (clk),
        .rst_n  (rst),
        .in_i   (fire),
        .rise_o (fire_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            proj_x_q <= '0;
            proj_y_q <= '0;
            active_q <= 1'b0;
            expl_q   <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (clear) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                active_q <= 1'b0;
                expl_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (fire_rise) begin
                            proj_x_q <= X_W'({1'b0, player_x} + LAUNCH_OFF);
                            proj_y_q <= LAUNCH_Y;
                            active_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= FLYING;
                        end
                    end
                    FLYING: begin
                        // A hit freezes the shot even on a move tick.
                        if (collision) begin
                            active_q <= 1'b0;
                            expl_q   <= 1'b1;
                            hit_q    <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= EXPLODE;
                        end else if (clk_move) begin
                            if (proj_y_q < SPEED) begin
                                active_q <= 1'b0;
                                miss_q   <= 1'b1;
                                cnt_q    <= '0;
                                state_q  <= COOLDOWN;
                            end else begin
                                proj_y_q <= proj_y_q - SPEED;
                            end
                        end
                    end
                    EXPLODE: begin
                        if (clk_move) begin
                            if (cnt_q == EXP_LAST) begin
                                expl_q  <= 1'b0;
                                cnt_q   <= '0;
                                state_q <= COOLDOWN;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (clk_move) begin
                            if (cnt_q == CD_LAST) begin
                                cnt_q   <= '0;
                                state_q <= IDLE;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign proj_x      = proj_x_q;
    assign proj_y      = proj_y_q;
    assign proj_active = active_q;
    assign exploding   = expl_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;

endmodule
